muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiplier and restoring divider share one 2*XLEN accumulator.
// Divide-by-zero and signed overflow complete without iterating.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] acc;
    logic              done_q;

    logic              accept, last, fast;
    logic              sgn_a, sgn_b, a_sign, b_sign, div_zero, div_ovf;
    logic [XLEN-1:0]   a_in_mag, b_in_mag, fast_res;

    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] acc_nx, prod;
    logic [XLEN-1:0]   quo, rem, calc_res;

    // Handshake, sign preprocessing and fast-path detection on the request inputs
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        accept    = req_valid && req_ready && !kill;
        last      = (cnt == CNT_W'(XLEN-1));
        sgn_a     = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_sign    = sgn_a && op_a[XLEN-1];
        b_sign    = sgn_b && op_b[XLEN-1];
        a_in_mag  = a_sign ? -op_a : op_a;
        b_in_mag  = b_sign ? -op_b : op_b;
        div_zero  = funct3[2] && (op_b == '0);
        div_ovf   = funct3[2] && !funct3[0] &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        fast      = div_zero || div_ovf;
        fast_res  = '0;
        if (div_zero)
            fast_res = funct3[1] ? op_a : '1;
        else if (div_ovf)
            fast_res = funct3[1] ? '0 : op_a;
    end

    // One iteration step and final sign fix-up / result selection
    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
        // Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
        div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, b_mag};
        if (!f3[2])
            acc_nx = {mul_sum, acc[XLEN-1:1]};
        else if (!div_trial[XLEN])
            acc_nx = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nx = {acc[2*XLEN-2:0], 1'b0};
        prod = (a_neg ^ b_neg) ? -acc_nx : acc_nx;
        quo  = (a_neg ^ b_neg) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rem  = a_neg ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        case (f3)
            3'b000:         calc_res = prod[XLEN-1:0];
            3'b100, 3'b101: calc_res = quo;
            3'b110, 3'b111: calc_res = rem;
            default:        calc_res = prod[2*XLEN-1:XLEN];
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = fast ? DONE : CALC;
            CALC:    if (kill) state_nx = IDLE;
                     else if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Operand capture, iteration datapath, result and done registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            f3     <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_mag  <= '0;
            acc    <= '0;
            result <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                f3    <= funct3;
                a_neg <= a_sign;
                b_neg <= b_sign;
                b_mag <= b_in_mag;
                acc   <= {{XLEN{1'b0}}, a_in_mag};
                cnt   <= '0;
                if (fast) begin
                    result <= fast_res;
                    done_q <= 1'b1;
                end
            end else if (state == CALC && !kill) begin
                acc <= acc_nx;
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    result <= calc_res;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // A flush arriving during the DONE cycle withdraws the pulse
    always_comb begin
        done = done_q && !kill;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// plain-arithmetic RV32M reference model.
module tb_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] last_res;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .kill      (kill),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M semantics using 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin up = ua * ub; return up[31:0]; end
            3'b001: begin sp = sa * sb; return sp[63:32]; end
            3'b010: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'b011: begin up = ua * ub; return up[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = sa / sb;
                return sp[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sp = sa % sb;
                return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned ref_lat(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Single request from IDLE; checks latency, busy length, result and pulse width.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int unsigned lat, busy_cnt;
        bit          seen;
        @(negedge clk);
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        funct3    = f;
        op_a      = a;
        op_b      = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        funct3    = 3'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        lat = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        check({tag, " latency"}, lat, ref_lat(f, a, b));
        check({tag, " busy cycles"}, busy_cnt, ref_lat(f, a, b));
        check({tag, " result"}, result, exp);
        @(negedge clk);
        check({tag, " done width"}, {31'b0, done}, 32'd0);
        check({tag, " result hold"}, result, exp);
        last_res = exp;
    endtask

    // Continuous requests: only cycles with req_ready high may produce an accept.
    task automatic b2b(input int unsigned ncyc);
        logic [31:0] q[$];
        logic [2:0]  f;
        logic [31:0] a, b;
        int unsigned n_acc, n_done, t;
        n_acc = 0; n_done = 0;
        for (int unsigned i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (q.size() == 0) check("b2b spurious done", 32'd1, 32'd0);
                else check("b2b result", result, q.pop_front());
            end
            f = 3'($urandom); a = pick(); b = pick();
            req_valid = 1'b1; funct3 = f; op_a = a; op_b = b;
            if (req_ready) begin
                q.push_back(ref_op(f, a, b));
                n_acc++;
            end
        end
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            req_valid = 1'b0;
            t++;
            if (done) begin
                n_done++;
                check("b2b result", result, q.pop_front());
            end
        end
        req_valid = 1'b0;
        check("b2b drained", q.size(), 32'd0);
        check("b2b done count", n_done, n_acc);
    endtask

    initial begin
        int unsigned k, n_spur;
        rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0;
        last_res = '0;
        #1;
        check("reset ready", {31'b0, req_ready}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul",         3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh",        3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu",       3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu",      3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div",         3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_op("rem",         3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_op("divu",        3'b101, 32'd100,       32'd7,         32'd14);
        run_op("remu",        3'b111, 32'd100,       32'd7,         32'd2);
        run_op("div by 0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF);
        run_op("rem by 0",    3'b110, 32'd5,         32'd0,         32'd5);
        run_op("divu by 0",   3'b101, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF);
        run_op("div ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // kill on CALC cycle 10 of a divu
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b101; op_a = $urandom; op_b = 32'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) kill = 1'b1;
        end
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill ready", {31'b0, req_ready}, 32'd1);
        check("kill busy", {31'b0, busy}, 32'd0);
        check("kill result", result, last_res);
        n_spur = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) n_spur++;
        end
        check("kill no done", n_spur, 32'd0);
        run_op("mul after kill", 3'b000, 32'd3, 32'd4, 32'd12);

        // kill in IDLE blocks acceptance
        @(negedge clk);
        req_valid = 1'b1; kill = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0; kill = 1'b0;
        check("idle kill busy", {31'b0, busy}, 32'd0);

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b000; op_a = $urandom; op_b = $urandom;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset ready", {31'b0, req_ready}, 32'd1);
        check("mid reset busy", {31'b0, busy}, 32'd0);
        check("mid reset done", {31'b0, done}, 32'd0);
        check("mid reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_spur = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) n_spur++;
        end
        check("reset no done", n_spur, 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom); a = pick(); b = pick();
            run_op("random", f, a, b, ref_op(f, a, b));
        end

        b2b(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
